// File: rtl/fifo_v3.sv
// Synchronous FIFO with optional fall-through; DEPTH=0 degenerates to a wire.
// Define FIFO_V3_ASSERT_EN to compile in simulation-only usage checks.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  dtype                  data_i,
  input  logic                  push_i,
  output dtype                  data_o,
  input  logic                  pop_i
);

  if (DEPTH == 0) begin : g_passthru
    // No storage: the consumer's pop is the only thing that frees the producer.
    logic unused_pt;
    assign unused_pt = clk_i ^ rst_ni ^ flush_i ^ testmode_i;

    assign data_o  = data_i;
    assign empty_o = ~push_i;
    assign full_o  = ~pop_i;
    assign usage_o = '0;

  end else begin : g_store
    localparam logic [ADDR_DEPTH-1:0] LAST_PTR = ADDR_DEPTH'(DEPTH - 1);
    localparam logic [ADDR_DEPTH:0]   FULL_CNT = (ADDR_DEPTH + 1)'(DEPTH);

    logic [ADDR_DEPTH-1:0] read_ptr_q, write_ptr_q;
    logic [ADDR_DEPTH:0]   count_q;
    dtype                  mem_q [DEPTH];
    logic                  is_empty, bypass, push_ok, pop_ok;
    logic                  unused_tm;

    assign unused_tm = testmode_i;

    function automatic logic [ADDR_DEPTH-1:0] bump(input logic [ADDR_DEPTH-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign is_empty = (count_q == '0);
    assign full_o   = (count_q == FULL_CNT);
    assign empty_o  = is_empty & ~(FALL_THROUGH & push_i);
    assign usage_o  = count_q[ADDR_DEPTH-1:0];
    assign data_o   = (FALL_THROUGH && is_empty) ? data_i : mem_q[read_ptr_q];

    // A word that enters and leaves in the same cycle never touches memory.
    assign bypass  = FALL_THROUGH & is_empty & push_i & pop_i;
    assign push_ok = push_i & ~full_o & ~bypass;
    assign pop_ok  = pop_i & ~empty_o & ~bypass;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        read_ptr_q  <= '0;
        write_ptr_q <= '0;
        count_q     <= '0;
        for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else if (flush_i) begin
        read_ptr_q  <= '0;
        write_ptr_q <= '0;
        count_q     <= '0;
      end else begin
        if (push_ok) begin
          mem_q[write_ptr_q] <= data_i;
          write_ptr_q        <= bump(write_ptr_q);
        end
        if (pop_ok) read_ptr_q <= bump(read_ptr_q);
        unique case ({push_ok, pop_ok})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end

`ifdef FIFO_V3_ASSERT_EN
    push_on_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o))
      else $error("fifo_v3: push while full");
    pop_on_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o))
      else $error("fifo_v3: pop while empty");
`endif
  end

`ifdef FIFO_V3_ASSERT_EN
  if (DEPTH == 0 && FALL_THROUGH && $bits(dtype) == 0) begin : g_cfg_chk
    $fatal(1, "fifo_v3: zero-width pass-through fall-through configuration");
  end
`else
`endif

endmodule

// File: tb/tb_fifo_v3.sv
// Bench for fifo_v3: three instances (4-deep, 4-deep fall-through, 3-deep)
// checked against queue models, directed scenarios followed by random traffic.
module tb_fifo_v3;
  typedef logic [7:0] q_t [$];

  logic       clk = 1'b0, rst_n = 1'b0, flush = 1'b0, tmode = 1'b0;
  logic       a_push, a_pop, b_push, b_pop, c_push, c_pop;
  logic [7:0] a_din, b_din, c_din, a_dout, b_dout, c_dout;
  logic       a_full, a_empty, b_full, b_empty, c_full, c_empty;
  logic [1:0] a_usage, b_usage, c_usage;

  q_t qs [3];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(4)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .testmode_i(tmode),
    .full_o(a_full), .empty_o(a_empty), .usage_o(a_usage),
    .data_i(a_din), .push_i(a_push), .data_o(a_dout), .pop_i(a_pop));
  fifo_v3 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(4)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .testmode_i(tmode),
    .full_o(b_full), .empty_o(b_empty), .usage_o(b_usage),
    .data_i(b_din), .push_i(b_push), .data_o(b_dout), .pop_i(b_pop));
  fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(3)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .testmode_i(tmode),
    .full_o(c_full), .empty_o(c_empty), .usage_o(c_usage),
    .data_i(c_din), .push_i(c_push), .data_o(c_dout), .pop_i(c_pop));

  // expected {full, empty, usage[1:0]} from occupancy alone
  function automatic logic [3:0] exp_st(int sz, int depth, bit ft, logic push);
    logic f, e;
    logic [1:0] u;
    f = (sz == depth);
    e = (sz == 0) && !(ft && push);
    u = sz[1:0];
    return {f, e, u};
  endfunction

  task automatic upd(int k, int depth, bit ft, logic push, logic pop, logic [7:0] din);
    int sz = qs[k].size();
    if (flush) qs[k].delete();
    else if (!(ft && sz == 0 && push && pop)) begin
      if (pop && sz != 0) void'(qs[k].pop_front());
      if (push && sz != depth) qs[k].push_back(din);
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    upd(0, 4, 1'b0, a_push, a_pop, a_din);
    upd(1, 4, 1'b1, b_push, b_pop, b_din);
    upd(2, 3, 1'b0, c_push, c_pop, c_din);
    #1;
  endtask

  task automatic idle();
    {a_push, a_pop, b_push, b_pop, c_push, c_pop} = '0;
    {a_din, b_din, c_din} = '0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    #2;
    n_chk++; if ({a_full, a_empty, a_usage, a_dout} !== 12'b0100_0000_0000) begin
      n_fail++; $display("FAIL reset_a: got %b/%h want 0100/00", {a_full, a_empty, a_usage}, a_dout); end
    n_chk++; if ({b_full, b_empty, b_usage, b_dout} !== 12'b0100_0000_0000) begin
      n_fail++; $display("FAIL reset_b: got %b/%h want 0100/00", {b_full, b_empty, b_usage}, b_dout); end
    n_chk++; if ({c_full, c_empty, c_usage, c_dout} !== 12'b0100_0000_0000) begin
      n_fail++; $display("FAIL reset_c: got %b/%h want 0100/00", {c_full, c_empty, c_usage}, c_dout); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_drain();
    logic [7:0] t [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      a_push = 1'b1; a_din = t[i]; #2;
      n_chk++; if ({a_full, a_empty, a_usage} !== exp_st(qs[0].size(), 4, 1'b0, a_push)) begin
        n_fail++; $display("FAIL fill_status[%0d]: got %b want %b", i, {a_full, a_empty, a_usage},
                           exp_st(qs[0].size(), 4, 1'b0, a_push)); end
      clk_step();
    end
    a_push = 1'b0; #2;
    n_chk++; if ({a_full, a_empty, a_usage} !== 4'b1000) begin
      n_fail++; $display("FAIL full_after_fill: got %b want 1000", {a_full, a_empty, a_usage}); end
    for (int i = 0; i < 4; i++) begin
      a_pop = 1'b1; #2;
      n_chk++; if (a_dout !== t[i]) begin
        n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, a_dout, t[i]); end
      clk_step();
    end
    a_pop = 1'b0; #2;
    n_chk++; if ({a_full, a_empty, a_usage} !== 4'b0100) begin
      n_fail++; $display("FAIL empty_after_drain: got %b want 0100", {a_full, a_empty, a_usage}); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] t [4] = '{8'h22, 8'h33, 8'h44, 8'h66};
    for (int i = 0; i < 4; i++) begin
      a_push = 1'b1; a_din = 8'h11 * 8'(i + 1); clk_step();
    end
    a_push = 1'b1; a_pop = 1'b1; a_din = 8'h55; #2;
    n_chk++; if ({a_full, a_dout} !== 9'h111) begin
      n_fail++; $display("FAIL full_pushpop_head: got %b/%h want 1/11", a_full, a_dout); end
    clk_step();
    a_push = 1'b0; a_pop = 1'b0; #2;
    n_chk++; if ({a_full, a_empty, a_usage} !== 4'b0011) begin
      n_fail++; $display("FAIL full_pushpop_cnt: got %b want 0011", {a_full, a_empty, a_usage}); end
    a_push = 1'b1; a_din = 8'h66; clk_step();
    a_din = 8'h55; #2;
    n_chk++; if ({a_full, a_empty, a_usage} !== 4'b1000) begin
      n_fail++; $display("FAIL refull: got %b want 1000", {a_full, a_empty, a_usage}); end
    clk_step();
    a_push = 1'b0; #2;
    n_chk++; if ({a_full, a_empty, a_usage} !== 4'b1000) begin
      n_fail++; $display("FAIL push_on_full: got %b want 1000", {a_full, a_empty, a_usage}); end
    for (int i = 0; i < 4; i++) begin
      a_pop = 1'b1; #2;
      n_chk++; if (a_dout !== t[i]) begin
        n_fail++; $display("FAIL full_drain[%0d]: got %h want %h", i, a_dout, t[i]); end
      clk_step();
    end
    a_pop = 1'b0; #2;
  endtask

  task automatic test_fall_through();
    b_push = 1'b1; b_din = 8'hAB; #2;
    n_chk++; if ({b_empty, b_dout} !== 9'h0AB) begin
      n_fail++; $display("FAIL ft_same_cycle: got %b/%h want 0/ab", b_empty, b_dout); end
    b_pop = 1'b1; #1;
    n_chk++; if ({b_empty, b_dout} !== 9'h0AB) begin
      n_fail++; $display("FAIL ft_bypass_comb: got %b/%h want 0/ab", b_empty, b_dout); end
    clk_step();
    b_push = 1'b0; b_pop = 1'b0; b_din = 8'h00; #2;
    n_chk++; if ({b_full, b_empty, b_usage} !== 4'b0100) begin
      n_fail++; $display("FAIL ft_bypass_cnt: got %b want 0100", {b_full, b_empty, b_usage}); end
    b_push = 1'b1; b_din = 8'hCD; clk_step();
    b_push = 1'b0; b_din = 8'h00; #2;
    n_chk++; if ({b_full, b_empty, b_usage, b_dout} !== 12'b0001_1100_1101) begin
      n_fail++; $display("FAIL ft_stored: got %b/%h want 0001/cd", {b_full, b_empty, b_usage}, b_dout); end
    b_pop = 1'b1; clk_step();
    b_pop = 1'b0; #2;
    n_chk++; if ({b_full, b_empty, b_usage} !== 4'b0100) begin
      n_fail++; $display("FAIL ft_drained: got %b want 0100", {b_full, b_empty, b_usage}); end
  endtask

  task automatic test_wrap();
    c_push = 1'b1; c_din = 8'h80; clk_step();
    for (int i = 0; i < 7; i++) begin
      c_push = 1'b1; c_pop = 1'b1; c_din = 8'(8'h81 + i); #2;
      n_chk++; if (c_dout !== 8'(8'h80 + i) || c_usage > 2'd3 || c_full !== 1'b0) begin
        n_fail++; $display("FAIL wrap[%0d]: got %h/%0d want %h/1", i, c_dout, c_usage, 8'(8'h80 + i)); end
      clk_step();
    end
    c_push = 1'b0; c_pop = 1'b1; #2;
    n_chk++; if ({c_usage, c_dout} !== 10'b01_1000_0111) begin
      n_fail++; $display("FAIL wrap_tail: got %0d/%h want 1/87", c_usage, c_dout); end
    clk_step();
    c_pop = 1'b0; #2;
    n_chk++; if ({c_full, c_empty, c_usage} !== 4'b0100) begin
      n_fail++; $display("FAIL wrap_empty: got %b want 0100", {c_full, c_empty, c_usage}); end
  endtask

  task automatic test_flush();
    a_push = 1'b1; a_din = 8'h01; clk_step();
    a_din = 8'h02; clk_step();
    a_din = 8'h03; flush = 1'b1; clk_step();
    a_push = 1'b0; flush = 1'b0; #2;
    n_chk++; if ({a_full, a_empty, a_usage} !== 4'b0100) begin
      n_fail++; $display("FAIL flush: got %b want 0100", {a_full, a_empty, a_usage}); end
    a_push = 1'b1; a_din = 8'h5A; clk_step();
    a_push = 1'b0; #2;
    n_chk++; if ({a_usage, a_dout} !== 10'b01_0101_1010) begin
      n_fail++; $display("FAIL post_flush_push: got %0d/%h want 1/5a", a_usage, a_dout); end
    a_pop = 1'b1; clk_step();
    a_pop = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      a_push = 1'b1; a_din = 8'(8'hA1 + i); clk_step();
    end
    a_push = 1'b0; #2;
    rst_n = 1'b0; #1;
    for (int k = 0; k < 3; k++) qs[k].delete();
    n_chk++; if ({a_full, a_empty, a_usage, a_dout} !== 12'b0100_0000_0000) begin
      n_fail++; $display("FAIL async_reset: got %b/%h want 0100/00", {a_full, a_empty, a_usage}, a_dout); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      a_pop = 1'b1; #2;
      n_chk++; if ({a_full, a_empty, a_usage} !== 4'b0100) begin
        n_fail++; $display("FAIL underflow[%0d]: got %b want 0100", i, {a_full, a_empty, a_usage}); end
      clk_step();
    end
    a_pop = 1'b0; #2;
    n_chk++; if ({a_full, a_empty, a_usage} !== 4'b0100) begin
      n_fail++; $display("FAIL underflow_end: got %b want 0100", {a_full, a_empty, a_usage}); end
  endtask

  task automatic test_random();
    int pp;
    for (int n = 0; n < 400; n++) begin
      pp = (n / 50) % 2 ? 30 : 70;
      a_push = ($urandom_range(0, 99) < pp); a_pop = ($urandom_range(0, 99) >= pp);
      b_push = ($urandom_range(0, 99) < pp); b_pop = ($urandom_range(0, 99) >= pp);
      c_push = ($urandom_range(0, 99) < pp); c_pop = ($urandom_range(0, 99) >= pp);
      a_din = 8'($urandom); b_din = 8'($urandom); c_din = 8'($urandom);
      flush = ($urandom_range(0, 39) == 0);
      #2;
      n_chk++; if ({a_full, a_empty, a_usage} !== exp_st(qs[0].size(), 4, 1'b0, a_push)) begin
        n_fail++; $display("FAIL rnd_a_status[%0d]: got %b want %b", n, {a_full, a_empty, a_usage},
                           exp_st(qs[0].size(), 4, 1'b0, a_push)); end
      n_chk++; if ({b_full, b_empty, b_usage} !== exp_st(qs[1].size(), 4, 1'b1, b_push)) begin
        n_fail++; $display("FAIL rnd_b_status[%0d]: got %b want %b", n, {b_full, b_empty, b_usage},
                           exp_st(qs[1].size(), 4, 1'b1, b_push)); end
      n_chk++; if ({c_full, c_empty, c_usage} !== exp_st(qs[2].size(), 3, 1'b0, c_push)) begin
        n_fail++; $display("FAIL rnd_c_status[%0d]: got %b want %b", n, {c_full, c_empty, c_usage},
                           exp_st(qs[2].size(), 3, 1'b0, c_push)); end
      if (qs[0].size() != 0) begin
        n_chk++; if (a_dout !== qs[0][0]) begin
          n_fail++; $display("FAIL rnd_a_data[%0d]: got %h want %h", n, a_dout, qs[0][0]); end
      end
      n_chk++; if (b_dout !== ((qs[1].size() != 0) ? qs[1][0] : b_din)) begin
        n_fail++; $display("FAIL rnd_b_data[%0d]: got %h want %h", n, b_dout,
                           (qs[1].size() != 0) ? qs[1][0] : b_din); end
      if (qs[2].size() != 0) begin
        n_chk++; if (c_dout !== qs[2][0]) begin
          n_fail++; $display("FAIL rnd_c_data[%0d]: got %h want %h", n, c_dout, qs[2][0]); end
      end
      clk_step();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_push_pop();
    test_fall_through();
    test_wrap();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
